// File: rtl/io_bus_uart_target_if.sv
// IO bus between the Nios external bus bridge and its targets.
// The initiator holds io_bus_enable until it sees io_acknowledge.
interface io_bus_uart_target_if;
  logic [15:0] io_address;
  logic        io_bus_enable;
  logic [1:0]  io_byte_enable;
  logic        io_rw;
  logic [15:0] io_write_data;
  logic [15:0] io_read_data;
  logic        io_acknowledge;
  logic        io_irq;

  modport master (
    output io_address, io_bus_enable, io_byte_enable,
    output io_rw, io_write_data,
    input  io_read_data, io_acknowledge, io_irq
  );

  modport slave (
    input  io_address, io_bus_enable, io_byte_enable,
    input  io_rw, io_write_data,
    output io_read_data, io_acknowledge, io_irq
  );
endinterface

// File: rtl/io_bus_uart_target.sv
// Memory-mapped 8N1 UART target on the 16-bit IO bus, with TX/RX FIFOs.
// Optional internal loopback (CTRL[2]) under macro IO_UART_LOOPBACK_EN.
module io_bus_uart_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       empty,
  output logic       full,
  output logic       drop
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [7:0]  mem_q [DEPTH];
  logic        do_push, do_pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  // a pop on a full FIFO frees the slot for a same-cycle push
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & ~do_push;
  assign rdata   = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q + {{AW{1'b0}}, do_push};
    rd_d = rd_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
  end
endmodule

module io_bus_uart_target #(
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic                        clk,
  input  logic                        reset,
  io_bus_uart_target_if.slave         bus,
  output logic                        uart_txd,
  input  logic                        uart_rxd
);
`ifdef IO_UART_LOOPBACK_EN
  localparam logic [2:0] CTRL_MASK = 3'b111;
`else
  localparam logic [2:0] CTRL_MASK = 3'b011;
`endif

  typedef enum logic [1:0] {
    B_IDLE, B_ACCESS, B_ACK, B_RELEASE
  } bus_st_t;
  typedef enum logic {TX_IDLE, TX_SHIFT} tx_st_t;
  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_st_t;

  bus_st_t     bus_st_q, bus_st_d;
  logic [2:0]  addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [15:0] baud_q, baud_d;
  logic        ovr_q, ovr_d, ovr_clr;
  logic        irq_q, irq_d;
  logic        sel, unused;

  tx_st_t      tx_st_q, tx_st_d;
  logic [9:0]  tx_sh_q, tx_sh_d;
  logic [3:0]  tx_bit_q, tx_bit_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [15:0] tx_div_q, tx_div_d;
  logic        tx_idle;

  rx_st_t      rx_st_q, rx_st_d;
  logic        rx_in, rx_s1_q, rx_s2_q, rx_prev_q;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [15:0] rx_div_q, rx_div_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;

  logic       txf_push, txf_pop, txf_empty, txf_full;
  logic       txf_drop_unused;
  logic [7:0] txf_rdata;
  logic       rxf_push, rxf_pop, rxf_empty, rxf_full;
  logic       rxf_drop;
  logic [7:0] rxf_rdata;

  assign unused = bus.io_address[0];
  assign sel = bus.io_bus_enable &
               (bus.io_address[15:4] == BASE_ADDR[15:4]);

  io_bus_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_txf (
    .clk(clk), .reset(reset),
    .push(txf_push), .pop(txf_pop),
    .wdata(wdata_q[7:0]), .rdata(txf_rdata),
    .empty(txf_empty), .full(txf_full),
    .drop(txf_drop_unused)
  );

  io_bus_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rxf (
    .clk(clk), .reset(reset),
    .push(rxf_push), .pop(rxf_pop),
    .wdata(rx_sh_q), .rdata(rxf_rdata),
    .empty(rxf_empty), .full(rxf_full),
    .drop(rxf_drop)
  );

  assign tx_idle = (tx_st_q == TX_IDLE) & txf_empty;

  always_comb begin
    bus_st_d = bus_st_q;
    addr_d   = addr_q;
    rw_d     = rw_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    ctrl_d   = ctrl_q;
    baud_d   = baud_q;
    txf_push = 1'b0;
    rxf_pop  = 1'b0;
    ovr_clr  = 1'b0;
    unique case (bus_st_q)
      B_IDLE: if (sel) begin
        addr_d   = bus.io_address[3:1];
        rw_d     = bus.io_rw;
        be_d     = bus.io_byte_enable;
        wdata_d  = bus.io_write_data;
        bus_st_d = B_ACCESS;
      end
      B_ACCESS: begin
        bus_st_d = B_ACK;
        rdata_d  = '0;
        if (rw_q) begin
          unique case (addr_q)
            3'd0: begin
              if (!rxf_empty) rdata_d = {7'b0, 1'b1, rxf_rdata};
              rxf_pop = be_q[0];
            end
            3'd1: rdata_d = {12'b0, ovr_q, tx_idle,
                             ~txf_full, ~rxf_empty};
            3'd2: rdata_d = {13'b0, ctrl_q};
            3'd3: rdata_d = baud_q;
            default: rdata_d = '0;
          endcase
        end else begin
          unique case (addr_q)
            3'd0: txf_push = be_q[0];
            3'd1: ovr_clr = be_q[0] & wdata_q[3];
            3'd2: if (be_q[0]) ctrl_d = wdata_q[2:0] & CTRL_MASK;
            3'd3: begin
              if (be_q[0]) baud_d[7:0]  = wdata_q[7:0];
              if (be_q[1]) baud_d[15:8] = wdata_q[15:8];
            end
            default: ;
          endcase
        end
      end
      B_ACK:     bus_st_d = B_RELEASE;
      B_RELEASE: if (!bus.io_bus_enable) bus_st_d = B_IDLE;
      default:   bus_st_d = B_IDLE;
    endcase
  end

  // a new overrun in the clearing cycle wins
  assign ovr_d = (ovr_q & ~ovr_clr) | rxf_drop;
  assign irq_d = (ctrl_q[0] & ~rxf_empty) |
                 (ctrl_q[1] & tx_idle) | ovr_q;

  assign bus.io_acknowledge = (bus_st_q == B_ACK);
  assign bus.io_read_data   = (bus_st_q == B_ACK) ? rdata_q : '0;
  assign bus.io_irq         = irq_q;

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_sh_d  = tx_sh_q;
    tx_bit_d = tx_bit_q;
    tx_cnt_d = tx_cnt_q;
    tx_div_d = tx_div_q;
    txf_pop  = 1'b0;
    unique case (tx_st_q)
      TX_IDLE: if (!txf_empty) begin
        txf_pop  = 1'b1;
        tx_sh_d  = {1'b1, txf_rdata, 1'b0};
        tx_bit_d = '0;
        tx_cnt_d = '0;
        tx_div_d = baud_q;
        tx_st_d  = TX_SHIFT;
      end
      TX_SHIFT: begin
        if (tx_cnt_q == tx_div_q) begin
          tx_cnt_d = '0;
          tx_div_d = baud_q;
          if (tx_bit_q == 4'd9) begin
            // chain the next frame straight after the stop bit
            if (!txf_empty) begin
              txf_pop  = 1'b1;
              tx_sh_d  = {1'b1, txf_rdata, 1'b0};
              tx_bit_d = '0;
            end else begin
              tx_sh_d = '1;
              tx_st_d = TX_IDLE;
            end
          end else begin
            tx_sh_d  = {1'b1, tx_sh_q[9:1]};
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      default: tx_st_d = TX_IDLE;
    endcase
  end

`ifdef IO_UART_LOOPBACK_EN
  assign rx_in    = ctrl_q[2] ? tx_sh_q[0] : uart_rxd;
  assign uart_txd = ctrl_q[2] ? 1'b1 : tx_sh_q[0];
`else
  assign rx_in    = uart_rxd;
  assign uart_txd = tx_sh_q[0];
`endif

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q;
    rx_div_d = rx_div_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rxf_push = 1'b0;
    unique case (rx_st_q)
      RX_IDLE: if (rx_prev_q & ~rx_s2_q) begin
        rx_cnt_d = '0;
        rx_div_d = baud_q;
        rx_st_d  = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == (rx_div_q >> 1)) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_st_d  = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == rx_div_q) begin
          rx_cnt_d = '0;
          rx_div_d = baud_q;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == rx_div_q) begin
          rxf_push = rx_s2_q;
          rx_st_d  = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_st_q  <= B_IDLE;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      ctrl_q    <= '0;
      baud_q    <= DEFAULT_DIV;
      ovr_q     <= 1'b0;
      irq_q     <= 1'b0;
      tx_st_q   <= TX_IDLE;
      tx_sh_q   <= '1;
      tx_bit_q  <= '0;
      tx_cnt_q  <= '0;
      tx_div_q  <= DEFAULT_DIV;
      rx_st_q   <= RX_IDLE;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_cnt_q  <= '0;
      rx_div_q  <= DEFAULT_DIV;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
    end else begin
      bus_st_q  <= bus_st_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      ctrl_q    <= ctrl_d;
      baud_q    <= baud_d;
      ovr_q     <= ovr_d;
      irq_q     <= irq_d;
      tx_st_q   <= tx_st_d;
      tx_sh_q   <= tx_sh_d;
      tx_bit_q  <= tx_bit_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_div_q  <= tx_div_d;
      rx_st_q   <= rx_st_d;
      rx_s1_q   <= rx_in;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_cnt_q  <= rx_cnt_d;
      rx_div_q  <= rx_div_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
    end
  end
endmodule

// File: tb/tb_io_bus_uart_target.sv
// Directed bench for io_bus_uart_target (default build or
// IO_UART_LOOPBACK_EN), using DIV=3 for all serial traffic.
module tb_io_bus_uart_target;
  logic clk = 1'b0;
  logic reset;
  logic uart_txd;
  logic uart_rxd;
  int   n_cmp = 0;
  int   n_bad = 0;

  io_bus_uart_target_if bus();

  io_bus_uart_target #(
    .BASE_ADDR(16'h0000), .FIFO_DEPTH(8), .DEFAULT_DIV(16'd433)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .uart_txd(uart_txd), .uart_rxd(uart_rxd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [15:0] a, input logic rw,
                      input logic [1:0] be, input logic [15:0] wd,
                      output logic [15:0] rd, output int lat);
    @(negedge clk);
    bus.io_address     = a;
    bus.io_rw          = rw;
    bus.io_byte_enable = be;
    bus.io_write_data  = wd;
    bus.io_bus_enable  = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.io_acknowledge && lat < 20);
    rd = bus.io_read_data;
    bus.io_bus_enable  = 1'b0;
    bus.io_rw          = 1'b0;
    bus.io_byte_enable = 2'b00;
    repeat (2) @(negedge clk);
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a,
                        input logic [1:0] be,
                        input logic [15:0] exp);
    logic [15:0] rd;
    int lat;
    xfer(a, 1'b1, be, 16'h0000, rd, lat);
    check({tag, "_lat"}, 16'(lat), 16'd2);
    check(tag, rd, exp);
  endtask

  task automatic wr(input string tag, input logic [15:0] a,
                    input logic [1:0] be, input logic [15:0] d);
    logic [15:0] rd;
    int lat;
    xfer(a, 1'b0, be, d, rd, lat);
    check({tag, "_lat"}, 16'(lat), 16'd2);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rxd = f[i];
      repeat (4) @(negedge clk);
    end
    uart_rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [39:0] cap;
    logic [9:0]  fr;
    logic [15:0] rd;
    int k, acks, nz;

    reset = 1'b1;
    uart_rxd = 1'b1;
    bus.io_address = '0;
    bus.io_bus_enable = 1'b0;
    bus.io_byte_enable = '0;
    bus.io_rw = 1'b0;
    bus.io_write_data = '0;
    repeat (3) @(negedge clk);
    check("rst_txd", {15'b0, uart_txd}, 16'h1);
    check("rst_irq", {15'b0, bus.io_irq}, 16'h0);
    check("rst_ack", {15'b0, bus.io_acknowledge}, 16'h0);
    check("rst_rdata", bus.io_read_data, 16'h0);
    reset = 1'b0;
    @(negedge clk);

    rd_chk("status_rst", 16'h0002, 2'b11, 16'h0006);
    rd_chk("baud_rst", 16'h0006, 2'b11, 16'd433);
    rd_chk("ctrl_rst", 16'h0004, 2'b11, 16'h0000);

    wr("ctrl_wr", 16'h0004, 2'b11, 16'hFFFF);
`ifdef IO_UART_LOOPBACK_EN
    rd_chk("ctrl_all", 16'h0004, 2'b11, 16'h0007);
`else
    rd_chk("ctrl_all", 16'h0004, 2'b11, 16'h0003);
`endif
    check("irq_tx_idle", {15'b0, bus.io_irq}, 16'h1);
    wr("ctrl_clr", 16'h0004, 2'b11, 16'h0000);
    check("irq_off", {15'b0, bus.io_irq}, 16'h0);

    wr("baud_lo", 16'h0006, 2'b01, 16'hAB03);
    rd_chk("baud_lo", 16'h0006, 2'b11, 16'h0103);
    wr("baud_hi", 16'h0006, 2'b10, 16'h0000);
    rd_chk("baud_div3", 16'h0006, 2'b11, 16'h0003);

    fr = {1'b1, 8'h55, 1'b0};
    cap = '0;
    fork
      wr("tx_push", 16'h0000, 2'b01, 16'h0055);
      begin
        k = 0;
        while (uart_txd !== 1'b0 && k < 100) begin
          @(negedge clk);
          k++;
        end
        for (int i = 0; i < 40; i++) begin
          cap[i] = uart_txd;
          @(negedge clk);
        end
      end
    join
    check("tx_start_seen", 16'(k < 100), 16'h1);
    for (int i = 0; i < 10; i++)
      check($sformatf("tx_bit%0d", i),
            {12'b0, cap[4*i +: 4]}, fr[i] ? 16'hF : 16'h0);
    repeat (4) @(negedge clk);
    rd_chk("tx_idle_again", 16'h0002, 2'b11, 16'h0006);

    send_rx(8'hA3, 1'b1);
    rd_chk("rx_a3", 16'h0000, 2'b01, 16'h01A3);
    rd_chk("rx_empty", 16'h0000, 2'b01, 16'h0000);

    send_rx(8'h5A, 1'b1);
    rd_chk("rx_peek", 16'h0000, 2'b10, 16'h015A);
    rd_chk("rx_pop", 16'h0000, 2'b01, 16'h015A);
    rd_chk("rx_empty2", 16'h0000, 2'b01, 16'h0000);

    uart_rxd = 1'b0;
    @(negedge clk);
    uart_rxd = 1'b1;
    repeat (20) @(negedge clk);
    rd_chk("false_start", 16'h0002, 2'b11, 16'h0006);

    send_rx(8'h77, 1'b0);
    rd_chk("framing_err", 16'h0002, 2'b11, 16'h0006);

    for (int i = 0; i < 9; i++) send_rx(8'h10 + 8'(i), 1'b1);
    rd_chk("ovr_status", 16'h0002, 2'b11, 16'h000F);
    check("ovr_irq", {15'b0, bus.io_irq}, 16'h1);
    for (int i = 0; i < 8; i++)
      rd_chk($sformatf("ovr_rd%0d", i), 16'h0000, 2'b01,
             16'h0110 + 16'(i));
    rd_chk("ovr_still", 16'h0002, 2'b11, 16'h000E);
    wr("ovr_clr", 16'h0002, 2'b01, 16'h0008);
    rd_chk("ovr_cleared", 16'h0002, 2'b11, 16'h0006);
    check("irq_cleared", {15'b0, bus.io_irq}, 16'h0);

    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    @(negedge clk);
    bus.io_address = 16'h0000;
    bus.io_rw = 1'b1;
    bus.io_byte_enable = 2'b01;
    bus.io_bus_enable = 1'b1;
    acks = 0;
    rd = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.io_acknowledge) begin
        acks++;
        rd = bus.io_read_data;
      end
    end
    bus.io_bus_enable = 1'b0;
    repeat (2) @(negedge clk);
    check("hold_acks", 16'(acks), 16'd1);
    check("hold_data", rd, 16'h0111);
    rd_chk("hold_next", 16'h0000, 2'b01, 16'h0122);
    rd_chk("hold_empty", 16'h0000, 2'b01, 16'h0000);

    @(negedge clk);
    bus.io_address = 16'h0010;
    bus.io_rw = 1'b1;
    bus.io_byte_enable = 2'b11;
    bus.io_bus_enable = 1'b1;
    acks = 0;
    nz = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.io_acknowledge) acks++;
      if (bus.io_read_data != 16'h0) nz++;
    end
    bus.io_bus_enable = 1'b0;
    repeat (2) @(negedge clk);
    check("unsel_ack", 16'(acks), 16'd0);
    check("unsel_rdata", 16'(nz), 16'd0);
    rd_chk("hole_0x8", 16'h0008, 2'b11, 16'h0000);

`ifdef IO_UART_LOOPBACK_EN
    wr("lb_ctrl", 16'h0004, 2'b11, 16'h0005);
    nz = 0;
    fork
      wr("lb_push", 16'h0000, 2'b01, 16'h003C);
      for (int i = 0; i < 80; i++) begin
        if (uart_txd !== 1'b1) nz++;
        @(negedge clk);
      end
    join
    check("lb_txd_high", 16'(nz), 16'd0);
    check("lb_irq", {15'b0, bus.io_irq}, 16'h1);
    rd_chk("lb_data", 16'h0000, 2'b01, 16'h013C);
    wr("lb_off", 16'h0004, 2'b11, 16'h0000);
`endif

    @(negedge clk);
    bus.io_address = 16'h0002;
    bus.io_rw = 1'b1;
    bus.io_byte_enable = 2'b11;
    bus.io_bus_enable = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    bus.io_bus_enable = 1'b0;
    acks = 0;
    @(negedge clk);
    if (bus.io_acknowledge) acks++;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.io_acknowledge) acks++;
    end
    check("abort_ack", 16'(acks), 16'd0);
    rd_chk("abort_baud", 16'h0006, 2'b11, 16'd433);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
